ahblite_bram_if: RTL
====================

# ahblite_bram_if

AHB-Lite slave front end for the on-chip dual-port block RAM that holds the Cortex-M0 code and data image. It decodes AHB-Lite transfers into the RAM's word-addressed read port and byte-enabled write port, and returns read data with zero wait states. It also resolves the read-after-write hazard created by committing writes in the data phase, and reports misaligned or oversized accesses with a two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 12, RAM word-address width (RAM depth is 2**ADDR_WIDTH words of 32 bits)
- HCLK  in  1  system clock; also clocks the RAM
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; bits [ADDR_WIDTH+1:2] used
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HWRITE  in  1  write when high
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- BRAM_RDADDR  out  ADDR_WIDTH  RAM read word address; RAM output is registered
- BRAM_WRADDR  out  ADDR_WIDTH  RAM write word address
- BRAM_WDATA  out  32  RAM write data
- BRAM_WRITE  out  4  RAM byte write enables
- BRAM_RDATA  in  32  RAM read data, one cycle after BRAM_RDADDR

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY.
- Byte lanes are decoded from HSIZE and HADDR[1:0]:
  - byte: one lane, selected by HADDR[1:0]
  - halfword: lanes 0-1 when HADDR[1]=0, lanes 2-3 when HADDR[1]=1
  - word: all four lanes
- Misaligned or illegal accesses: halfword with HADDR[0]=1, word with HADDR[1:0]≠0, or HSIZE>2.
  - Go to ERR1 and do not touch the RAM.
- Read:
  - BRAM_RDADDR = HADDR word bits, combinationally, in the address phase.
  - HRDATA = BRAM_RDATA in the data phase.
- Write:
  - The address phase registers the word address and lane mask.
  - In the data phase: BRAM_WRADDR = registered address, BRAM_WDATA = HWDATA, BRAM_WRITE = registered mask.
  - The RAM commits the write at the end of the data phase.
- RAW hazard: a read is accepted while a write to the same word is in its data phase.
  - The registered RAM output would return stale data.
  - Resolution is set by the configuration macro (see Configuration).
- States:
  - IDLE/ACTIVE: HREADYOUT=1, HRESP=0.
  - STALL: HREADYOUT=0, HRESP=0. BRAM_RDADDR comes from the held read address. Returns to ACTIVE after one cycle.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Goes to ACTIVE, or to ERR1 if another illegal access is accepted.
- When no transfer is accepted, BRAM_WRITE=0 in the following cycle.
- IDLE or BUSY transfers, and HSEL=0, give an OKAY zero-wait response.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, BRAM_WRITE=0, state ACTIVE, hazard flag 0, registered mask 0.
- Read latency: data is valid in the first data-phase cycle, with zero wait states (no hazard, or forwarding enabled).
- Hazard without forwarding: exactly one wait state.
- Write: one cycle, zero wait states. Back-to-back writes commit on consecutive edges.
- Error: exactly two data-phase cycles.
- Reset asserted mid-operation:
  - A pending write is discarded, because the mask register clears and BRAM_WRITE=0 after the edge.
  - A pending STALL or ERR state returns to ACTIVE with reset outputs.
- A write following a read to the same word needs no handling: the read data already came from the pre-write contents.

## Configuration
- BRAM_RAW_FWD_EN defined:
  - On a hazard, register the write lane mask and HWDATA.
  - In the read data phase, HRDATA takes forwarded bytes on masked lanes and BRAM_RDATA bytes elsewhere.
  - No wait state is inserted.
- BRAM_RAW_FWD_EN undefined:
  - On a hazard, enter STALL for one cycle and re-issue the held read address.
  - HRDATA is taken from BRAM_RDATA in the following cycle.

## Structure
- Shared package ahb_pkg:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE constants
  - HRESP constants
  - state enum (ACTIVE, STALL, ERR1, ERR2)
- Sub-module ahb_byte_lane_dec:
  - inputs HSIZE and HADDR[1:0]
  - outputs the 4-bit lane mask and the misaligned flag
  - purely combinational; reused by other AHB slaves

## Test plan
- Word write 0x11223344 to 0x100, idle, read 0x100 -> HRDATA=0x11223344, HREADYOUT stays 1.
- Byte write 0xAB to 0x103 over 0x11223344, then read word 0x100 -> 0xAB223344, BRAM_WRITE=4'b1000 during the write data phase.
- Back-to-back halfword write 0xBEEF to 0x102 then read 0x100 (same word) -> 0xBEEF3344; with forwarding, zero wait; without, exactly one HREADYOUT=0 cycle.
- Word access to 0x101 -> HRESP=1 for two cycles (HREADYOUT 0 then 1), BRAM_WRITE stays 0, RAM contents unchanged.
- HRESET asserted during a write data phase to 0x200 (old 0x0) -> BRAM_WRITE=0 after the edge, later read of 0x200 returns 0x0, HREADYOUT=1, HRESP=0.
- Read of the last word 0x3FFC (ADDR_WIDTH=12) with HADDR[31:14]≠0 -> BRAM_RDADDR=0xFFF, upper bits ignored.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, sizes, response codes and the
// slave front-end state encoding. Imported by every AHB slave in this slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Byte-lane decoder for 32-bit AHB-Lite slaves. Turns HSIZE and the low two
// address bits into a 4-bit lane mask and flags misaligned or oversized
// accesses (the mask is zero whenever the access is flagged).
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_haddr,
  output logic [3:0] o_mask,
  output logic       o_misaligned
);

  // Lane selection and alignment check, purely combinational.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    o_mask       = 4'b0000;
    o_misaligned = 1'b0;
    case (i_hsize)
      HSIZE_BYTE: o_mask = 4'b0001 << i_haddr;
      HSIZE_HALF: begin
        if (i_haddr[0]) o_misaligned = 1'b1;
        else            o_mask       = i_haddr[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (i_haddr != 2'b00) o_misaligned = 1'b1;
        else                  o_mask       = 4'b1111;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahblite_bram_if.sv
// AHB-Lite slave front end for the dual-port code/data block RAM.
// Reads are issued to the RAM combinationally in the address phase and return
// in the data phase with zero wait states; writes are committed in the data
// phase. A read to the word being written in the same cycle is a RAW hazard:
//   BRAM_RAW_FWD_EN defined   : the write bytes are forwarded into HRDATA.
//   BRAM_RAW_FWD_EN undefined : one STALL cycle re-reads the held address.
// Misaligned or oversized accesses get a two-cycle ERROR response.
module ahblite_bram_if
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

`ifdef BRAM_RAW_FWD_EN
  localparam bit STALL_ON_HAZARD = 1'b0;
`else
  localparam bit STALL_ON_HAZARD = 1'b1;
`endif

  state_e                r_state;
  state_e                w_next_state;
  logic [3:0]            r_wr_mask;   // nonzero only while a write is in its data phase
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic [3:0]            w_mask;
  logic                  w_misaligned;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_xfer;
  logic                  w_err_acc;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_hazard;
  logic                  w_unused_haddr;

  ahb_byte_lane_dec u_lane_dec (
    .i_hsize      (HSIZE),
    .i_haddr      (HADDR[1:0]),
    .o_mask       (w_mask),
    .o_misaligned (w_misaligned)
  );

  // Upper address bits lie outside the RAM and are deliberately ignored.
  assign w_unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  assign w_word_addr = HADDR[ADDR_WIDTH+1:2];
  assign w_xfer      = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign w_err_acc   = w_xfer &&  w_misaligned;
  assign w_wr_acc    = w_xfer && !w_misaligned &&  HWRITE;
  assign w_rd_acc    = w_xfer && !w_misaligned && !HWRITE;
  assign w_hazard    = w_rd_acc && (r_wr_mask != 4'b0000) && (r_wr_addr == w_word_addr);

  assign BRAM_WRADDR = r_wr_addr;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRITE  = r_wr_mask;

  // Control state: FSM and the write lane mask, both cleared by reset so a
  // pending write is dropped before it reaches the RAM.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (HRESET) begin
      r_state   <= ST_ACTIVE;
      r_wr_mask <= 4'b0000;
    end else begin
      r_state   <= w_next_state;
      r_wr_mask <= w_wr_acc ? w_mask : 4'b0000;
    end
  end

  // Address holding registers; only meaningful while r_wr_mask or r_state
  // marks them live.
  always_ff @(posedge HCLK) begin
    // NOTE: these datapath registers are not reset; their qualifiers are, so a
    // stale address can never reach the RAM or the bus.
    if (w_wr_acc) r_wr_addr <= w_word_addr;
    if (w_rd_acc) r_rd_addr <= w_word_addr;
  end

  // Next-state and bus response decode.
  always_comb begin
    w_next_state = r_state;
    HREADYOUT    = 1'b1;
    HRESP        = HRESP_OKAY;
    BRAM_RDADDR  = w_word_addr;
    case (r_state)
      ST_ACTIVE, ST_ERR2: begin
        if (r_state == ST_ERR2) HRESP = HRESP_ERROR;
        if (w_err_acc)                        w_next_state = ST_ERR1;
        else if (w_hazard && STALL_ON_HAZARD) w_next_state = ST_STALL;
        else                                  w_next_state = ST_ACTIVE;
      end
      ST_STALL: begin
        HREADYOUT    = 1'b0;
        BRAM_RDADDR  = r_rd_addr;
        w_next_state = ST_ACTIVE;
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_next_state = ST_ERR2;
      end
      default: w_next_state = ST_ACTIVE;
    endcase
  end

`ifdef BRAM_RAW_FWD_EN
  logic [3:0]  r_fwd_mask;  // nonzero marks a forwarded (hazard) read data phase
  logic [31:0] r_fwd_data;

  // Capture the colliding write's lanes and data for the hazard read.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_fwd_mask <= 4'b0000;
    else        r_fwd_mask <= w_hazard ? r_wr_mask : 4'b0000;
    if (w_hazard) r_fwd_data <= HWDATA;
  end

  // Merge forwarded bytes over the (stale) RAM output.
  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (r_fwd_mask[i]) HRDATA[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end
`else
  assign HRDATA = BRAM_RDATA;
`endif

endmodule
